// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver (start, 8 data LSB first, optional parity, stop) driven by an oversample tick.
// Build option UART_RX_MAJORITY_EN: decide each bit by a 2-of-3 vote over the ticks around mid-bit.
module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       os_tick,
  input  logic       rx,
  input  logic       par_en,
  input  logic       par_ty,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);

`ifdef UART_RX_MAJORITY_EN
  // Decisions land one tick after mid-bit so the third vote sample is available.
  localparam logic [CW-1:0] START_PT = CW'(OVERSAMPLE / 2);
`else
  localparam logic [CW-1:0] START_PT = CW'(OVERSAMPLE / 2 - 1);
`endif
  localparam logic [CW-1:0] BIT_PT = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rxs;
  logic                   rxs_prev;
  logic                   fall;
  logic                   bit_val;
  logic                   at_pt;
  logic [CW-1:0]          tick_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_reg;
  logic                   pe_lat;
  logic                   pt_lat;
  logic                   perr_lat;
  logic                   stop_lat;
  logic                   done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '1;
      rxs_prev <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
      rxs_prev <= rxs;
    end
  end

  assign rxs  = sync_reg[SYNC_STAGES-1];
  assign fall = rxs_prev & ~rxs;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // hist[0] is rxs at the previous tick, hist[1] the tick before that.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= 2'b11;
    end else if (os_tick) begin
      hist <= {hist[0], rxs};
    end
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
  assign bit_val = rxs;
`endif

  assign at_pt = os_tick && (tick_cnt == ((state == START) ? START_PT : BIT_PT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      pe_lat     <= 1'b0;
      pt_lat     <= 1'b0;
      perr_lat   <= 1'b0;
      stop_lat   <= 1'b1;
      done       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (done) begin
        // Publish the frame one clk after the stop-bit decision.
        done       <= 1'b0;
        rx_valid   <= 1'b1;
        rx_data    <= shift_reg;
        parity_err <= pe_lat & perr_lat;
        frame_err  <= ~stop_lat;
        state      <= IDLE;
        rx_busy    <= 1'b0;
        tick_cnt   <= '0;
      end else begin
        if (state != IDLE && os_tick) begin
          tick_cnt <= tick_cnt + 1'b1;
        end
        case (state)
          IDLE: begin
            if (fall) begin
              state    <= START;
              tick_cnt <= '0;
              rx_busy  <= 1'b1;
            end
          end
          START: begin
            if (at_pt) begin
              tick_cnt <= '0;
              if (!bit_val) begin
                state    <= DATA;
                bit_cnt  <= '0;
                pe_lat   <= par_en;
                pt_lat   <= par_ty;
                perr_lat <= 1'b0;
              end else begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end
          end
          DATA: begin
            if (at_pt) begin
              tick_cnt  <= '0;
              shift_reg <= {bit_val, shift_reg[7:1]};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) begin
                state <= pe_lat ? PARITY : STOP;
              end
            end
          end
          PARITY: begin
            if (at_pt) begin
              tick_cnt <= '0;
              perr_lat <= bit_val != (pt_lat ? ^shift_reg : ~^shift_reg);
              state    <= STOP;
            end
          end
          STOP: begin
            if (at_pt) begin
              tick_cnt <= '0;
              stop_lat <= bit_val;
              done     <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: builds serial streams one os_tick slot at a time, decodes them with a slot-level
// reference model into a scoreboard queue, and a monitor compares every rx_valid strobe.
`timescale 1ns/1ps
module tb_uart_rx;

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       os_tick;
  logic       rx = 1'b1;
  logic       par_en = 1'b0;
  logic       par_ty = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;
  logic [1:0] div_cnt = 2'd0;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_e;
  bit   slot_rx[$];
  bit   slot_pe[$];
  bit   slot_pt[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   strobes = 0;

  uart_rx #(
    .OVERSAMPLE (OS),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .os_tick   (os_tick),
    .rx        (rx),
    .par_en    (par_en),
    .par_ty    (par_ty),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) div_cnt <= div_cnt + 2'd1;
  assign os_tick = (div_cnt == 2'd3);

  // Scoreboard monitor: one line per received byte.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      strobes++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL strobe: unexpected rx_valid data=%02h perr=%0b ferr=%0b, no byte required",
                 rx_data, parity_err, frame_err);
      end else begin
        exp_e = exp_q.pop_front();
        if ({rx_data, parity_err, frame_err} !== exp_e) begin
          miscompares++;
          $display("FAIL byte %0d: got data=%02h perr=%0b ferr=%0b, required data=%02h perr=%0b ferr=%0b",
                   strobes, rx_data, parity_err, frame_err, exp_e.data, exp_e.perr, exp_e.ferr);
        end else begin
          $display("byte %0d: data=%02h perr=%0b ferr=%0b ok", strobes, rx_data, parity_err, frame_err);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // One slot = one os_tick period; rx changes right after a tick and holds until the next one.
  task automatic drive_slot(input bit v, input bit pe, input bit pt);
    rx     = v;
    par_en = pe;
    par_ty = pt;
    @(posedge clk);
    while (os_tick !== 1'b1) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void push_slots(input bit v, input int n, input bit pe, input bit pt);
    for (int i = 0; i < n; i++) begin
      slot_rx.push_back(v);
      slot_pe.push_back(pe);
      slot_pt.push_back(pt);
    end
  endfunction

  function automatic void add_frame(input logic [7:0] d, input bit pe, input bit pt, input bit bad_par,
                                    input bit stop_v, input int glitch, input bit scramble);
    bit f[$];
    bit pbit;
    for (int i = 0; i < OS; i++) f.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < OS; i++) f.push_back(d[k]);
    pbit = (pt ? ^d : ~^d) ^ bad_par;
    if (pe)
      for (int i = 0; i < OS; i++) f.push_back(pbit);
    for (int i = 0; i < OS; i++) f.push_back(stop_v);
    if (glitch >= 0) f[glitch] = ~f[glitch];
    for (int i = 0; i < f.size(); i++) begin
      slot_rx.push_back(f[i]);
      slot_pe.push_back((scramble && i >= 24) ? 1'($urandom) : pe);
      slot_pt.push_back((scramble && i >= 24) ? 1'($urandom) : pt);
    end
  endfunction

  // Line value a receiver decides for a bit whose mid-bit slot is c.
  function automatic bit samp(input int c);
    int ones;
    if (MAJ != 0) begin
      ones = int'(slot_rx[c-1]) + int'(slot_rx[c]) + int'(slot_rx[c+1]);
      return ones >= 2;
    end
    return slot_rx[c];
  endfunction

  // Reference decoder: a frame starts at a high-to-low slot boundary seen while idle; each bit is
  // judged at slot 7 of its 16-slot period; idle resumes right after the stop decision.
  function automatic void decode();
    int         n;
    int         i;
    int         s;
    int         pos;
    logic [7:0] d;
    bit         pe;
    bit         pt;
    exp_t       e;
    n = slot_rx.size();
    i = 1;
    while (i < n) begin
      if (slot_rx[i-1] && !slot_rx[i]) begin
        s = i;
        if (s + OS * 11 + 2 >= n) break;
        if (samp(s + 7)) begin
          i = s + 7 + MAJ + 1;
          continue;
        end
        pe = slot_pe[s+7];
        pt = slot_pt[s+7];
        for (int k = 0; k < 8; k++) d[k] = samp(s + OS * (k + 1) + 7);
        pos    = s + OS * 9 + 7;
        e.perr = 1'b0;
        if (pe) begin
          e.perr = samp(pos) != (pt ? ^d : ~^d);
          pos += OS;
        end
        e.ferr = !samp(pos);
        e.data = d;
        exp_q.push_back(e);
        i = pos + MAJ + 1;
      end else begin
        i++;
      end
    end
  endfunction

  function automatic void clear_slots();
    slot_rx.delete();
    slot_pe.delete();
    slot_pt.delete();
  endfunction

  task automatic run_segment(input int probe_idx, input bit probe_val, input string probe_name);
    decode();
    for (int i = 0; i < slot_rx.size(); i++) begin
      drive_slot(slot_rx[i], slot_pe[i], slot_pt[i]);
      if (i == probe_idx) check(probe_name, 32'(rx_busy), 32'(probe_val));
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
    clear_slots();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(rx_valid), 0);
    check({tag, "_busy"}, 32'(rx_busy), 0);
    check({tag, "_data"}, 32'(rx_data), 0);
    check({tag, "_perr"}, 32'(parity_err), 0);
    check({tag, "_ferr"}, 32'(frame_err), 0);
  endtask

  initial begin
    logic [7:0] d;
    bit         pe;
    bit         pt;
    bit         bad;
    bit         stop_v;
    int         g;
    int         gap;
    int         s0;
    int         offs[4] = '{3, 6, 7, 8};

    rst = 1'b1;
    repeat (6) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Plain byte, no parity; rx_busy probed in the middle of the frame.
    push_slots(1'b1, 4, 1'b0, 1'b0);
    add_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    push_slots(1'b1, 24, 1'b0, 1'b0);
    run_segment(4 + 80, 1'b1, "busy_mid_frame");
    check("a5_data", 32'(rx_data), 32'h A5);
    check("a5_busy_after", 32'(rx_busy), 0);

    // Parity: even ok, odd ok, even with wrong parity bit last.
    push_slots(1'b1, 4, 1'b1, 1'b1);
    add_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0);
    push_slots(1'b1, 4, 1'b1, 1'b0);
    add_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    push_slots(1'b1, 4, 1'b1, 1'b1);
    add_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b0);
    push_slots(1'b1, 24, 1'b0, 1'b0);
    run_segment(-1, 1'b0, "");
    check("par_bad_data", 32'(rx_data), 32'h3C);
    check("par_bad_flag", 32'(parity_err), 1);

    // Reset during data bit 4 aborts the frame.
    push_slots(1'b1, 4, 1'b0, 1'b0);
    add_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    for (int i = 0; i < 4 + OS * 5 + 8; i++) drive_slot(slot_rx[i], slot_pe[i], slot_pt[i]);
    check("busy_before_rst", 32'(rx_busy), 1);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    clear_slots();
    push_slots(1'b1, 4, 1'b0, 1'b0);
    add_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    push_slots(1'b1, 24, 1'b0, 1'b0);
    run_segment(-1, 1'b0, "");
    check("after_rst_data", 32'(rx_data), 32'hC3);

    // Framing error, line held low, then a fresh frame.
    s0 = strobes;
    push_slots(1'b1, 4, 1'b0, 1'b0);
    add_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    push_slots(1'b0, 40, 1'b0, 1'b0);
    push_slots(1'b1, 4, 1'b0, 1'b0);
    add_frame(8'hE7, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    push_slots(1'b1, 24, 1'b0, 1'b0);
    run_segment(-1, 1'b0, "");
    check("ferr_strobes", strobes - s0, 2);

    // Start glitch, then a real frame.
    push_slots(1'b1, 4, 1'b0, 1'b0);
    push_slots(1'b0, 3, 1'b0, 1'b0);
    push_slots(1'b1, 20, 1'b0, 1'b0);
    add_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    push_slots(1'b1, 24, 1'b0, 1'b0);
    run_segment(4 + 9, 1'b0, "busy_after_glitch");
    check("glitch_next_data", 32'(rx_data), 32'h81);

    // Back-to-back frames with no idle gap.
    s0 = strobes;
    push_slots(1'b1, 4, 1'b0, 1'b0);
    add_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    add_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    add_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    push_slots(1'b1, 24, 1'b0, 1'b0);
    run_segment(-1, 1'b0, "");
    check("b2b_strobes", strobes - s0, 3);
    check("b2b_last", 32'(rx_data), 32'h5A);

    // One-slot low glitch on the mid-bit of bit 7.
    push_slots(1'b1, 4, 1'b0, 1'b0);
    add_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, OS * 8 + 7, 1'b0);
    push_slots(1'b1, 24, 1'b0, 1'b0);
    run_segment(-1, 1'b0, "");
    check("mid_glitch_data", 32'(rx_data), (MAJ != 0) ? 32'hF0 : 32'h70);

    // Random frames: parity modes, bad parity/stop, single-slot glitches, parity inputs toggled mid-frame.
    for (int seg = 0; seg < 3; seg++) begin
      push_slots(1'b1, 4, 1'b0, 1'b0);
      for (int f = 0; f < 10; f++) begin
        d      = 8'($urandom);
        pe     = 1'($urandom);
        pt     = 1'($urandom);
        bad    = ($urandom_range(0, 3) == 0);
        stop_v = ($urandom_range(0, 5) != 0);
        g      = -1;
        if ($urandom_range(0, 3) == 0) g = OS * $urandom_range(1, 8) + offs[$urandom_range(0, 3)];
        add_frame(d, pe, pt, bad, stop_v, g, 1'b1);
        gap = $urandom_range(0, 5);
        if (!stop_v && gap < 2) gap = 2;
        push_slots(1'b1, gap, pe, pt);
      end
      push_slots(1'b1, 24, 1'b0, 1'b0);
      run_segment(-1, 1'b0, "");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
